// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with multi-beat ready/valid refill, flush and hit/miss counters.
// Replacement: define ICACHE_LRU_EN for true LRU; otherwise a 16-bit LFSR picks the victim.
module icache_set_assoc #(
    parameter int WAYS           = 4,
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      PC,
    input  logic             Fetch_Valid,
    input  logic             Flush,
    output logic             HitWrite,
    output logic [31:0]      Data_Cache,
    output logic             MM_Req,
    output logic [31:0]      MM_Addr,
    input  logic             MM_Ready,
    input  logic [31:0]      MM_Data,
    output logic [CNT_W-1:0] CNT_HIT,
    output logic [CNT_W-1:0] CNT_MISS
);

    localparam int WB = $clog2(WAYS);
    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int SB = $clog2(SETS);
    localparam int SW = (SB > 0) ? SB : 1;
    localparam int TL = 2 + OB + SB;
    localparam int TW = 32 - TL;
    localparam int LW = 30 - OB;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

    state_t state, state_nx;

    logic [WAYS-1:0] valid_mem [SETS];
    logic [TW-1:0]   tag_mem   [WAYS][SETS];
    logic [31:0]     data_mem  [WAYS][SETS][WORDS_PER_LINE];

    logic [OB-1:0]   pc_off;
    logic [SW-1:0]   pc_set;
    logic [TW-1:0]   pc_tag;

    logic [LW-1:0]   req_line;
    logic [OB-1:0]   req_off;
    logic [SW-1:0]   req_set;
    logic [TW-1:0]   req_tag;
    logic [WB-1:0]   victim_r;
    logic [OB-1:0]   beat;
    logic            flush_pend;

    logic            hit;
    logic [WB-1:0]   hit_way;
    logic            inv_found;
    logic [WB-1:0]   inv_way;
    logic [WB-1:0]   policy_way;
    logic [WB-1:0]   victim_pick;

    logic            flush_now;
    logic            lookup_hit;
    logic            miss_start;
    logic            beat_ok;
    logic            last_beat;

    logic [CNT_W-1:0] cnt_hit;
    logic [CNT_W-1:0] cnt_miss;

    logic            unused_pc;
    assign unused_pc = ^PC[1:0];

    assign pc_off  = PC[2+OB-1:2];
    assign pc_tag  = PC[31:TL];
    assign req_tag = req_line[LW-1:SB];

    if (SB > 0) begin : g_set
        assign pc_set  = PC[TL-1:2+OB];
        assign req_set = req_line[SB-1:0];
    end else begin : g_noset
        assign pc_set  = '0;
        assign req_set = '0;
    end

    assign flush_now  = (state == S_IDLE) && (Flush || flush_pend);
    assign lookup_hit = (state == S_IDLE) && Fetch_Valid && !flush_now && hit;
    assign miss_start = (state == S_IDLE) && Fetch_Valid && !flush_now && !hit;
    assign beat_ok    = (state == S_REFILL) && MM_Ready;
    assign last_beat  = beat_ok && (beat == OB'(WORDS_PER_LINE - 1));

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_mem[pc_set][w] && (tag_mem[w][pc_set] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!inv_found && !valid_mem[pc_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
        victim_pick = inv_found ? inv_way : policy_way;
    end

`ifdef ICACHE_LRU_EN
    logic [WB-1:0] age_mem [SETS][WAYS];
    logic          acc_en;
    logic [SW-1:0] acc_set;
    logic [WB-1:0] acc_way;

    assign acc_en  = lookup_hit || last_beat;
    assign acc_set = lookup_hit ? pc_set : req_set;
    assign acc_way = lookup_hit ? hit_way : victim_r;

    always_comb begin
        policy_way = '0;
        for (int unsigned w = 0; w < WAYS; w++)
            if (age_mem[pc_set][w] == WB'(WAYS - 1))
                policy_way = WB'(w);
    end

    // Ways younger than the accessed way age by one; the accessed way becomes youngest.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned s = 0; s < SETS; s++)
                for (int unsigned w = 0; w < WAYS; w++)
                    age_mem[s][w] <= WB'(w);
        end else if (acc_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WB'(w) == acc_way)
                    age_mem[acc_set][w] <= '0;
                else if (age_mem[acc_set][w] < age_mem[acc_set][acc_way])
                    age_mem[acc_set][w] <= age_mem[acc_set][w] + 1'b1;
            end
        end
    end
`else
    logic [15:0] lfsr;

    assign policy_way = lfsr[WB-1:0];

    always_ff @(posedge CLK) begin
        if (RESET) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    always_comb begin
        state_nx   = state;
        HitWrite   = 1'b0;
        Data_Cache = '0;
        MM_Req     = 1'b0;
        MM_Addr    = '0;
        unique case (state)
            S_IDLE: begin
                if (lookup_hit) begin
                    HitWrite   = 1'b1;
                    Data_Cache = data_mem[hit_way][pc_set][pc_off];
                end
                if (miss_start) state_nx = S_REFILL;
            end
            S_REFILL: begin
                MM_Req  = 1'b1;
                MM_Addr = {req_line, beat, 2'b00};
                if (last_beat) state_nx = S_DONE;
            end
            S_DONE: begin
                HitWrite   = 1'b1;
                Data_Cache = data_mem[victim_r][req_set][req_off];
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            flush_pend <= 1'b0;
            beat       <= '0;
            req_line   <= '0;
            req_off    <= '0;
            victim_r   <= '0;
            cnt_hit    <= '0;
            cnt_miss   <= '0;
        end else begin
            state <= state_nx;
            // A flush seen outside IDLE is held until the first IDLE cycle applies it.
            if (state == S_IDLE) flush_pend <= 1'b0;
            else if (Flush)      flush_pend <= 1'b1;
            if (miss_start) begin
                req_line <= PC[31:2+OB];
                req_off  <= pc_off;
                victim_r <= victim_pick;
                beat     <= '0;
            end else if (beat_ok) begin
                beat <= beat + 1'b1;
            end
            if (lookup_hit && (cnt_hit != '1))  cnt_hit  <= cnt_hit + 1'b1;
            if (miss_start && (cnt_miss != '1)) cnt_miss <= cnt_miss + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush_now) begin
            for (int unsigned s = 0; s < SETS; s++)
                valid_mem[s] <= '0;
        end else if (last_beat) begin
            valid_mem[req_set][victim_r] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && last_beat) tag_mem[victim_r][req_set] <= req_tag;
        if (!RESET && beat_ok)   data_mem[victim_r][req_set][beat] <= MM_Data;
    end

    assign CNT_HIT  = cnt_hit;
    assign CNT_MISS = cnt_miss;

endmodule

// File: doc/icache_set_assoc.md
# icache_set_assoc

Parametrised N-way set-associative instruction cache for the 5-stage MIPS pipeline's IF stage. It is the successor to the fully-associative random-replacement cache. It adds configurable ways, sets and line size, multi-beat line refill over a ready/valid main-memory handshake, whole-cache flush, saturating hit/miss counters, and selectable LRU or random replacement. The cache returns the instruction combinationally on a hit. `HitWrite` gates `PCWrite` and IF/ID advance upstream.

## Interface
Parameters:
- `WAYS`, 4: associativity; power of 2, ≥2.
- `SETS`, 8: sets; power of 2, ≥1.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of 2, ≥2.
- `CNT_W`, 20: width of hit/miss counters.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `PC`  in  32  fetch byte address; bits [1:0] ignored.
- `Fetch_Valid`  in  1  fetch request this cycle.
- `Flush`  in  1  invalidate all lines.
- `HitWrite`  out  1  `Data_Cache` is valid this cycle; 0 = stall.
- `Data_Cache`  out  32  fetched instruction.
- `MM_Req`  out  1  refill beat request.
- `MM_Addr`  out  32  byte address of the current beat.
- `MM_Ready`  in  1  memory accepts the beat; `MM_Data` is valid.
- `MM_Data`  in  32  refill word.
- `CNT_HIT`  out  `CNT_W`  hit counter.
- `CNT_MISS`  out  `CNT_W`  miss counter.

## Operation
- Address split: word offset = `PC[2+OB-1:2]`, where OB = log2(`WORDS_PER_LINE`). Set = next log2(`SETS`) bits. Tag = remaining upper bits.
- Storage per way and set: valid bit, tag, `WORDS_PER_LINE` data words.
- FSM states:
  - IDLE: lookup. Hit → `HitWrite`=1, `Data_Cache`=word, replacement state updated. Miss with `Fetch_Valid` → latch `PC`, select victim, go to REFILL.
  - REFILL: `MM_Req`=1. `MM_Addr` = line base + 4×beat, with beats 0..`WORDS_PER_LINE`-1. The beat advances only on a cycle with `MM_Ready`=1; `MM_Data` is written into the victim way. On the last accepted beat, write tag and valid, update replacement state, go to DONE.
  - DONE: one cycle. `HitWrite`=1, `Data_Cache` = latched requested word. Then go to IDLE.
- Victim selection: the lowest-index invalid way; otherwise the replacement policy (see Configuration).
- `Fetch_Valid`=0 in IDLE → `HitWrite`=0, no counting, no refill.
- PC changes during REFILL/DONE are ignored. DONE returns the word of the latched address; upstream holds `PC` while `HitWrite`=0.
- Flush:
  - In IDLE: clears all valid bits at the edge. `HitWrite` is forced to 0 that cycle and nothing is counted.
  - In REFILL/DONE: the flush is latched as pending. It is applied on the first IDLE cycle, and that cycle behaves as an IDLE flush.
- Counters: `CNT_HIT` +1 per IDLE hit with `Fetch_Valid`. `CNT_MISS` +1 per IDLE→REFILL transition. Both saturate at all ones.
- Reset values:
  - State IDLE; all valid bits 0; counters 0; flush-pending 0.
  - `MM_Req`=0, `MM_Addr`=0, `HitWrite`=0, `Data_Cache`=0.
  - LRU ages: way i = i. LFSR = 16'hACE1.
- Reset during REFILL abandons the refill. No partial line becomes valid.

## Timing
- Hit: zero latency. `Data_Cache` and `HitWrite` are combinational from `PC` in IDLE.
- Miss detected in cycle t: `HitWrite`=0 in t. `MM_Req`=1 from t+1.
- With `MM_Ready` held at 1: beats in cycles t+1..t+`WORDS_PER_LINE`, DONE in t+`WORDS_PER_LINE`+1, IDLE after that.
- Each cycle with `MM_Ready`=0 in REFILL adds one cycle of latency; `MM_Addr` holds.
- `MM_Req` drops in the DONE cycle.

## Configuration
- `ICACHE_LRU_EN` defined: true LRU. Each set keeps a log2(`WAYS`)-bit age per way. The accessed or filled way gets age 0; ways with a smaller age than its old age increment. Victim = way with age `WAYS`-1.
- Not defined: pseudo-random replacement. A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. Victim = LFSR[log2(`WAYS`)-1:0]. No per-set age storage.

## Test plan
All scenarios use defaults: offset `PC[3:2]`, set `PC[6:4]`, tag `PC[31:7]`.
- Cold miss: after reset, `PC`=0x0, `Fetch_Valid`=1, `MM_Ready`=1 → `HitWrite`=0 in cycles 0–4. `MM_Addr` = 0x0, 0x4, 0x8, 0xC in cycles 1–4. DONE in cycle 5 with `HitWrite`=1. Then `PC`=0x4 hits the same cycle. Result: `CNT_HIT`=1, `CNT_MISS`=1.
- Backpressure: `MM_Ready` alternating 1,0 during refill → `MM_Addr` holds on ready=0 cycles. DONE arrives 8 cycles after miss detection. Data is correct.
- LRU (`ICACHE_LRU_EN`):
  - Fill 0x000, 0x080, 0x100, 0x180 (set 0), then hit 0x000.
  - Fetch 0x200 → evicts 0x080.
  - Then 0x000 hits and 0x080 misses.
- Flush:
  - `Flush`=1 in IDLE after fills → the next 0x0 fetch misses.
  - `Flush` pulsed during REFILL → DONE still returns the word. The next fetch of the same line misses.
- Saturation: `CNT_W`=4, 20 consecutive hits → `CNT_HIT`=15.
- Reset mid-refill: `RESET`=1 during beat 2 → next cycle `MM_Req`=0 and counters 0. A re-fetch of the same line misses.
